// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Serial-request bus arbiter. Each master raises its arbCont_M line with a
//   start bit, shifts in a slave ID (MSB first), then holds the line high to
//   keep the request or ownership. A per-master receiver FSM decodes the frame.
//   A central arbiter grants the bus, holds it until the owner releases, and
//   inserts one idle turnaround cycle between owners.
//
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   : round-robin winner selection, starting after the last owner
//     undefined : fixed priority, lowest master index wins
//
// Ports
//   clk        : clock, rising edge
//   rstN       : asynchronous active-low reset
//   arbCont_M  : per-master serial request/hold line
//   ready      : ready of the currently selected slave
//   bus_state  : {master_id, slave_id}, all zeros when the bus is free
//   grant_M    : per-master grant, high while that master owns the bus
// -----------------------------------------------------------------------------
// Receiver FSM (one per master)
//   state    | meaning
//   IDLE     | waiting for a start bit
//   ADDR     | shifting in slave-ID bits
//   PEND     | valid request waiting for a grant
//   OWN      | master owns the bus
//   WAIT_LOW | invalid ID received, waiting for the line to drop
//
// Arbiter FSM
//   state    | meaning
//   FREE     | no owner, may grant on the next edge
//   BUSY     | bus owned, watching for release
//   TURN     | one idle turnaround cycle before FREE
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             arbCont_M [0:NO_MASTERS-1],
  input  logic                             ready,
  output logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state,
  output logic                             grant_M   [0:NO_MASTERS-1]
);

  localparam int BUS_W = S_ID_WIDTH + M_ID_WIDTH;
  localparam int CNT_W = (S_ID_WIDTH > 1) ? $clog2(S_ID_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S_ID_WIDTH - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_ADDR,
    RX_PEND,
    RX_OWN,
    RX_WAIT_LOW
  } rx_state_t;

  typedef enum logic [1:0] {
    ARB_FREE,
    ARB_BUSY,
    ARB_TURN
  } arb_state_t;

  rx_state_t             rx_q    [NO_MASTERS];
  rx_state_t             rx_nxt  [NO_MASTERS];
  logic [CNT_W-1:0]      cnt_q   [NO_MASTERS];
  logic [CNT_W-1:0]      cnt_nxt [NO_MASTERS];
  logic [S_ID_WIDTH-1:0] sid_q   [NO_MASTERS];
  logic [S_ID_WIDTH-1:0] sid_nxt [NO_MASTERS];
  logic [S_ID_WIDTH:0]   id_full;

  arb_state_t            arb_q, arb_nxt;
  logic [BUS_W-1:0]      bus_q, bus_nxt;
  logic [NO_MASTERS-1:0] gnt_q, gnt_nxt;
  logic                  rel_q, rel_nxt;

  logic [NO_MASTERS-1:0] line;
  logic [NO_MASTERS-1:0] elig;
  logic [NO_MASTERS-1:0] grant_now;
  logic [NO_MASTERS-1:0] release_now;
  logic                  win_found;
  logic [M_ID_WIDTH-1:0] win_id;
  logic [M_ID_WIDTH-1:0] owner;

  assign owner = bus_q[BUS_W-1:S_ID_WIDTH];

  // A pending master whose line is already low is aborting this cycle, so it
  // must not be granted on the same edge.
  always_comb begin
    line = '0;
    elig = '0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      line[i] = arbCont_M[i];
      elig[i] = (rx_q[i] == RX_PEND) && arbCont_M[i];
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [M_ID_WIDTH-1:0] last_q;
  logic [M_ID_WIDTH-1:0] rr_sel;
  int                    rr_idx;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    rr_sel    = '0;
    for (int k = 0; k < NO_MASTERS; k++) begin
      rr_idx = (int'(last_q) + 1 + k) % NO_MASTERS;
      rr_sel = M_ID_WIDTH'(rr_idx);
      if (!win_found && elig[rr_sel]) begin
        win_found = 1'b1;
        win_id    = rr_sel;
      end
    end
  end

  // Reset value makes master 0 the first in line after reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last_q <= M_ID_WIDTH'(NO_MASTERS - 1);
    end else if (arb_q == ARB_FREE && win_found) begin
      last_q <= win_id;
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NO_MASTERS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_found = 1'b1;
        win_id    = M_ID_WIDTH'(i);
      end
    end
  end
`endif

  // Arbiter next state. A release request seen while ready=0 is remembered in
  // rel_q so the owner need not keep its line low until the slave is ready.
  always_comb begin
    arb_nxt     = arb_q;
    bus_nxt     = bus_q;
    gnt_nxt     = gnt_q;
    rel_nxt     = rel_q;
    grant_now   = '0;
    release_now = '0;
    case (arb_q)
      ARB_FREE: begin
        if (win_found) begin
          grant_now[win_id] = 1'b1;
          gnt_nxt           = grant_now;
          bus_nxt           = {win_id, sid_q[win_id]};
          arb_nxt           = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (rel_q || !line[owner]) begin
          if (ready) begin
            release_now[owner] = 1'b1;
            bus_nxt            = '0;
            gnt_nxt            = '0;
            rel_nxt            = 1'b0;
            arb_nxt            = ARB_TURN;
          end else begin
            rel_nxt = 1'b1;
          end
        end
      end
      ARB_TURN: arb_nxt = ARB_FREE;
      default:  arb_nxt = ARB_FREE;
    endcase
  end

  // Receiver next state. ID bits in ADDR are data and may legitimately be 0;
  // a master that drops its line mid-frame ends up either with an invalid ID
  // (WAIT_LOW) or in PEND with the line low, which aborts on the next edge.
  always_comb begin
    id_full = '0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      rx_nxt[i]  = rx_q[i];
      cnt_nxt[i] = cnt_q[i];
      sid_nxt[i] = sid_q[i];
      id_full    = {sid_q[i], line[i]};
      case (rx_q[i])
        RX_IDLE: begin
          if (line[i]) begin
            rx_nxt[i]  = RX_ADDR;
            cnt_nxt[i] = '0;
            sid_nxt[i] = '0;
          end
        end
        RX_ADDR: begin
          sid_nxt[i] = id_full[S_ID_WIDTH-1:0];
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
          if (cnt_q[i] == CNT_LAST) begin
            if ((id_full[S_ID_WIDTH-1:0] != '0) &&
                (int'(id_full[S_ID_WIDTH-1:0]) <= NO_SLAVES)) begin
              rx_nxt[i] = RX_PEND;
            end else begin
              rx_nxt[i] = RX_WAIT_LOW;
            end
          end
        end
        RX_PEND: begin
          if (!line[i]) begin
            rx_nxt[i] = RX_IDLE;
          end else if (grant_now[i]) begin
            rx_nxt[i] = RX_OWN;
          end
        end
        RX_OWN: begin
          if (release_now[i]) rx_nxt[i] = RX_IDLE;
        end
        RX_WAIT_LOW: begin
          if (!line[i]) rx_nxt[i] = RX_IDLE;
        end
        default: rx_nxt[i] = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      arb_q <= ARB_FREE;
      bus_q <= '0;
      gnt_q <= '0;
      rel_q <= 1'b0;
      for (int i = 0; i < NO_MASTERS; i++) begin
        rx_q[i]  <= RX_IDLE;
        cnt_q[i] <= '0;
        sid_q[i] <= '0;
      end
    end else begin
      arb_q <= arb_nxt;
      bus_q <= bus_nxt;
      gnt_q <= gnt_nxt;
      rel_q <= rel_nxt;
      for (int i = 0; i < NO_MASTERS; i++) begin
        rx_q[i]  <= rx_nxt[i];
        cnt_q[i] <= cnt_nxt[i];
        sid_q[i] <= sid_nxt[i];
      end
    end
  end

  assign bus_state = bus_q;

  for (genvar g = 0; g < NO_MASTERS; g++) begin : g_grant
    assign grant_M[g] = gnt_q[g];
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed bench for bus_arbiter (2 masters, 3 slaves). A table of
//   per-cycle {line0, line1, ready, expected bus_state, expected grants}
//   records is replayed from reset, followed by a hand-written asynchronous
//   reset sequence.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic       arbCont_M [0:1];
  logic       ready;
  logic [2:0] bus_state;
  logic       grant_M   [0:1];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       m0;
    logic       m1;
    logic       rdy;
    logic [2:0] bus;
    logic [1:0] gnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  bus_arbiter #(
    .NO_MASTERS (2),
    .NO_SLAVES  (3)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .arbCont_M (arbCont_M),
    .ready     (ready),
    .bus_state (bus_state),
    .grant_M   (grant_M)
  );

  function automatic logic [1:0] gnt_vec();
    return {grant_M[1], grant_M[0]};
  endfunction

  task automatic cmp(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic a0, input logic a1, input logic r);
    arbCont_M[0] = a0;
    arbCont_M[1] = a1;
    ready        = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic m0, input logic m1, input logic rdy,
                     input logic [2:0] bus, input logic [1:0] gnt);
    vec_t v;
    v.m0  = m0;
    v.m1  = m1;
    v.rdy = rdy;
    v.bus = bus;
    v.gnt = gnt;
    vecs.push_back(v);
  endtask

  initial begin
    // A: master 1 requests slave 2 (1,1,0), owns, releases
    add(0, 1, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b110, 2'b10);
    add(0, 1, 1, 3'b110, 2'b10);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    // B: first conflict, m0 -> slave 1, m1 -> slave 3; m0 wins in both modes
    add(1, 1, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b000, 2'b00);
    add(1, 1, 1, 3'b000, 2'b00);
    add(1, 1, 1, 3'b001, 2'b01);
    add(1, 1, 1, 3'b001, 2'b01);
    add(0, 1, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b111, 2'b10);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    // D: m0 -> slave 3, drops line with ready low for 4 cycles
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b011, 2'b01);
    add(0, 0, 0, 3'b011, 2'b01);
    add(0, 0, 0, 3'b011, 2'b01);
    add(0, 0, 0, 3'b011, 2'b01);
    add(0, 0, 0, 3'b011, 2'b01);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    // C: second conflict, m0 -> slave 2, m1 -> slave 1
    add(1, 1, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b000, 2'b00);
`ifdef ARB_ROUND_ROBIN_EN
    add(1, 1, 1, 3'b101, 2'b10);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b010, 2'b01);
    add(0, 0, 1, 3'b000, 2'b00);
`else
    add(1, 1, 1, 3'b010, 2'b01);
    add(0, 1, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b101, 2'b10);
    add(0, 0, 1, 3'b000, 2'b00);
`endif
    add(0, 0, 1, 3'b000, 2'b00);
    // G: m0 owns slave 3; m1 frames slave 2 meanwhile, then aborts in PEND
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 1, 1, 3'b011, 2'b01);
    add(1, 1, 1, 3'b011, 2'b01);
    add(1, 0, 1, 3'b011, 2'b01);
    add(1, 0, 1, 3'b011, 2'b01);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    // E: m0 sends slave 0 (1,0,0) and holds; then a valid frame to slave 1
    add(1, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b000, 2'b00);
    add(1, 0, 1, 3'b001, 2'b01);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    // F: m1 starts a frame and drops its line partway: never granted
    add(0, 1, 1, 3'b000, 2'b00);
    add(0, 1, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);
    add(0, 0, 1, 3'b000, 2'b00);

    // Reset state, checked before the first clock edge
    drive(0, 0, 1);
    rstN = 1'b0;
    #1;
    cmp("reset_bus", 0, 8'(bus_state), 8'h00);
    cmp("reset_gnt", 0, 8'(gnt_vec()), 8'h00);
    tick();
    rstN = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].m0, vecs[i].m1, vecs[i].rdy);
      tick();
      cmp("vec_bus", i, 8'(bus_state), 8'(vecs[i].bus));
      cmp("vec_gnt", i, 8'(gnt_vec()), 8'(vecs[i].gnt));
    end

    // Asynchronous reset during ownership: m1 owns slave 3, reset mid-cycle
    drive(0, 1, 1);
    tick();
    tick();
    tick();
    tick();
    cmp("rst_own_bus", 0, 8'(bus_state), 8'h07);
    cmp("rst_own_gnt", 0, 8'(gnt_vec()), 8'h02);
    #2;
    rstN = 1'b0;
    #1;
    cmp("rst_async_bus", 0, 8'(bus_state), 8'h00);
    cmp("rst_async_gnt", 0, 8'(gnt_vec()), 8'h00);
    drive(0, 0, 1);
    tick();
    cmp("rst_hold_bus", 0, 8'(bus_state), 8'h00);
    cmp("rst_hold_gnt", 0, 8'(gnt_vec()), 8'h00);

    // Fresh frame right after deassertion: m1 -> slave 1, start on first edge
    rstN = 1'b1;
    drive(0, 1, 1);
    tick();
    cmp("rst_fresh_bus", 0, 8'(bus_state), 8'h00);
    drive(0, 0, 1);
    tick();
    cmp("rst_fresh_bus", 1, 8'(bus_state), 8'h00);
    drive(0, 1, 1);
    tick();
    cmp("rst_fresh_bus", 2, 8'(bus_state), 8'h00);
    tick();
    cmp("rst_fresh_bus", 3, 8'(bus_state), 8'h05);
    cmp("rst_fresh_gnt", 3, 8'(gnt_vec()), 8'h02);
    drive(0, 0, 1);
    tick();
    cmp("rst_fresh_bus", 4, 8'(bus_state), 8'h00);
    cmp("rst_fresh_gnt", 4, 8'(gnt_vec()), 8'h00);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
